sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
- Downstream stage of the per-sprite display blocks (fireball, Bowser, Mario, etc.).
- Generates the 640x480 raster counters (hcount/vcount) that every display block consumes, and collects each block's 24-bit RGB_output as one layer.
- Merges the layers by fixed priority with colour-key transparency and drives the registered VGA pins.
- Takes frame-synchronous control from the same 32-bit command word format the display blocks decode.

Parameters:
- NUM_LAYERS, 8, number of sprite layers; layer 0 has the highest priority.
- TRANSPARENT_RGB, 24'h202020, colour-key value; a layer outputting this value is transparent.
- BG_RGB_RESET, 24'h5C94FC, background colour after reset.
- COMPONENT_ID, 6'b000000, command ID this block responds to.

Ports:
- clk  in  1  pixel clock, one pixel per cycle.
- reset  in  1  asynchronous, active-high reset.
- write  in  1  command strobe; writedata is valid when high.
- writedata  in  32  command word: [31:26] component, [20:17] action, [16:14] action_type, [12:0] action_data.
- layer_rgb  in  NUM_LAYERS*24  layer k occupies bits [24k+23:24k]; combinational function of the hcount/vcount driven out this cycle.
- hcount  out  10  current pixel column, 0..799.
- vcount  out  10  current line, 0..524.
- frame_start  out  1  single-cycle pulse while hcount==0 and vcount==0.
- VGA_R / VGA_G / VGA_B  out  8 each  pixel colour.
- VGA_HS, VGA_VS  out  1  syncs, active low.
- VGA_BLANK_n  out  1  high during the visible area.
- collision  out  NUM_LAYERS  per-frame collision flags (see Optional Feature).

Behaviour:
- Raster timing, horizontal: 800-count total = 640 visible, front porch 16, sync 96 (hcount 656..751), back porch 48.
- Raster timing, vertical: 525-line total = 480 visible, front porch 10, sync 2 (vcount 490..491), back porch 33.
- hcount wraps 799->0 and increments vcount; vcount wraps 524->0.
- Reset state: hcount=0, vcount=0, all pipeline registers 0, VGA RGB=0, HS=VS=1, BLANK_n=0, active and shadow enable mask = all ones, bg = BG_RGB_RESET, collision=0.
- Pipeline stage 1: register layer_rgb, plus visible/HS/VS derived from the counters.
- Pipeline stage 2: priority select and output register. The pixel for counter value at cycle t appears on the VGA pins at t+2.
- HS, VS and BLANK_n are delayed by exactly the same 2 cycles, so they stay aligned with the pixel data.
- Layer k is opaque when active_mask[k]=1 and its rgb != TRANSPARENT_RGB.
- Output = rgb of the lowest-index opaque layer. If no layer is opaque, output = active bg.
- During blanking, RGB = 0 regardless of the layers.
- Commands are accepted only when write=1 and component==COMPONENT_ID; all others are ignored. Accepted commands write shadow registers only.
  - action 4'h1: shadow_mask <= action_data[NUM_LAYERS-1:0].
  - action 4'h2, action_type 0/1/2: shadow_bg R/G/B <= action_data[7:0].
  - action 4'hF: shadow_mask = all ones, shadow_bg = BG_RGB_RESET.
  - Other action/action_type codes are ignored.
- Commit: on the frame_start cycle, active <= shadow.
- A write in the same cycle as frame_start lands in shadow and takes effect at the following frame. The commit uses pre-write shadow values.
- Asynchronous reset mid-frame forces the counters to 0 immediately; frame_start asserts on the first cycle after release.

Optional Feature:
- Macro: SPRITE_COMPOSITOR_COLLISION_EN.
- When defined:
  - During visible pixels, if layer 0 and layer k (k>=1) are both opaque in the same stage-2 pixel, a sticky flag sets for k.
  - At frame_start, collision <= sticky flags and the sticky flags clear.
  - Bit 0 of collision is always 0.
- When not defined: no sticky logic; collision is tied to 0.

Decomposition:
- Package compositor_pkg holds:
  - H/V visible, porch, sync and total constants.
  - Command field bit positions.
  - Action codes ACT_SET_MASK=4'h1, ACT_SET_BG=4'h2, ACT_RESTORE=4'hF.
  - Colour-channel enum for action_type.
- One sub-module, vga_timing_gen: counters, HS/VS/visible and frame_start generation.
- Compositing, command decode and collision logic stay in the top module.

Test Plan:
- Reset release, run 800*525 cycles -> exactly one frame_start per frame; HS low for 96 cycles per line; VS low during lines 490-491; BLANK_n high for 640x480 pixels only.
- Layer0=TRANSPARENT_RGB, layer3=24'hFF0000, others transparent, at counters (100,50) -> VGA_RGB=FF0000 two cycles later with BLANK_n=1.
- Layer1=00FF00 and layer2=0000FF, both opaque -> output 00FF00. Then send mask 8'hFD mid-frame -> still 00FF00 until the next frame_start, then 0000FF.
- Send bg R=0x12, G=0x34, B=0x56 with all layers transparent -> next frame outputs 123456. A write issued in the frame_start cycle takes effect one frame later.
- Write with component != COMPONENT_ID, then action 4'hF -> first changes nothing; after the next frame, mask=FF and bg=5C94FC. Assert reset mid-line -> counters read 0 and VGA RGB=0 immediately.
- With SPRITE_COMPOSITOR_COLLISION_EN: layers 0 and 4 opaque at one visible pixel -> after the next frame_start collision=8'h10, and it clears to 00 after a following frame with no overlap. Without the macro, collision stays 0.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared raster timing, command-word layout and action codes for the sprite compositor.
package compositor_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int CMD_COMP_HI = 31;
  localparam int CMD_COMP_LO = 26;
  localparam int CMD_ACT_HI  = 20;
  localparam int CMD_ACT_LO  = 17;
  localparam int CMD_TYPE_HI = 16;
  localparam int CMD_TYPE_LO = 14;
  localparam int CMD_DATA_HI = 12;
  localparam int CMD_DATA_LO = 0;

  typedef enum logic [3:0] {
    ACT_SET_MASK = 4'h1,
    ACT_SET_BG   = 4'h2,
    ACT_RESTORE  = 4'hF
  } action_e;

  typedef enum logic [2:0] {
    CH_RED   = 3'd0,
    CH_GREEN = 3'd1,
    CH_BLUE  = 3'd2
  } channel_e;

endpackage

// File: rtl/vga_timing_gen.sv
// 640x480 raster counters with sync/visible decode and a frame_start pulse at (0,0).
module vga_timing_gen
  import compositor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       visible,
  output logic       hsync_on,
  output logic       vsync_on,
  output logic       frame_start
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == 10'(H_TOTAL - 1)) begin
      hcount <= '0;
      vcount <= (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  // Sync flags are active-high here; the top inverts them at the pins.
  assign visible     = (hcount < 10'(H_VISIBLE)) && (vcount < 10'(V_VISIBLE));
  assign hsync_on    = (hcount >= 10'(H_SYNC_START)) && (hcount <= 10'(H_SYNC_END));
  assign vsync_on    = (vcount >= 10'(V_SYNC_START)) && (vcount <= 10'(V_SYNC_END));
  assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);

endmodule

// File: rtl/sprite_compositor.sv
// Priority/colour-key merge of sprite layers onto registered VGA pins, two-cycle pipeline.
// Optional per-frame layer-0 collision flags under `SPRITE_COMPOSITOR_COLLISION_EN.
module sprite_compositor
  import compositor_pkg::*;
#(
  parameter int          NUM_LAYERS      = 8,
  parameter logic [23:0] TRANSPARENT_RGB = 24'h202020,
  parameter logic [23:0] BG_RGB_RESET    = 24'h5C94FC,
  parameter logic [5:0]  COMPONENT_ID    = 6'b000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [31:0]              writedata,
  input  logic [NUM_LAYERS*24-1:0] layer_rgb,
  output logic [9:0]               hcount,
  output logic [9:0]               vcount,
  output logic                     frame_start,
  output logic [7:0]               VGA_R,
  output logic [7:0]               VGA_G,
  output logic [7:0]               VGA_B,
  output logic                     VGA_HS,
  output logic                     VGA_VS,
  output logic                     VGA_BLANK_n,
  output logic [NUM_LAYERS-1:0]    collision
);

  logic visible, hsync_on, vsync_on;

  vga_timing_gen u_timing (
    .clk         (clk),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .visible     (visible),
    .hsync_on    (hsync_on),
    .vsync_on    (vsync_on),
    .frame_start (frame_start)
  );

  logic          cmd_hit;
  action_e       action;
  channel_e      channel;
  logic [12:0]   action_data;
  logic          unused_cmd;

  assign cmd_hit     = write && (writedata[CMD_COMP_HI:CMD_COMP_LO] == COMPONENT_ID);
  assign action      = action_e'(writedata[CMD_ACT_HI:CMD_ACT_LO]);
  assign channel     = channel_e'(writedata[CMD_TYPE_HI:CMD_TYPE_LO]);
  assign action_data = writedata[CMD_DATA_HI:CMD_DATA_LO];
  assign unused_cmd  = ^writedata;

  logic [NUM_LAYERS-1:0] shadow_mask, active_mask;
  logic [23:0]           shadow_bg, active_bg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_mask <= '1;
      shadow_bg   <= BG_RGB_RESET;
    end else if (cmd_hit) begin
      case (action)
        ACT_SET_MASK: shadow_mask <= action_data[NUM_LAYERS-1:0];
        ACT_SET_BG: begin
          case (channel)
            CH_RED:   shadow_bg[23:16] <= action_data[7:0];
            CH_GREEN: shadow_bg[15:8]  <= action_data[7:0];
            CH_BLUE:  shadow_bg[7:0]   <= action_data[7:0];
            default:  ;
          endcase
        end
        ACT_RESTORE: begin
          shadow_mask <= '1;
          shadow_bg   <= BG_RGB_RESET;
        end
        default: ;
      endcase
    end
  end

  // Commit samples the shadow before any same-cycle write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_mask <= '1;
      active_bg   <= BG_RGB_RESET;
    end else if (frame_start) begin
      active_mask <= shadow_mask;
      active_bg   <= shadow_bg;
    end
  end

  logic [NUM_LAYERS*24-1:0] s1_layers;
  logic                     s1_visible, s1_hsync, s1_vsync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_layers  <= '0;
      s1_visible <= 1'b0;
      s1_hsync   <= 1'b0;
      s1_vsync   <= 1'b0;
    end else begin
      s1_layers  <= layer_rgb;
      s1_visible <= visible;
      s1_hsync   <= hsync_on;
      s1_vsync   <= vsync_on;
    end
  end

  logic [NUM_LAYERS-1:0] opaque;
  logic [23:0]           pixel;

  always_comb begin
    for (int k = 0; k < NUM_LAYERS; k++) begin
      opaque[k] = active_mask[k] && (s1_layers[24*k +: 24] != TRANSPARENT_RGB);
    end
  end

  // Walk from lowest priority up so the lowest-index opaque layer wins.
  always_comb begin
    pixel = active_bg;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (opaque[k]) pixel = s1_layers[24*k +: 24];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_n <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= s1_visible ? pixel : 24'h0;
      VGA_HS      <= ~s1_hsync;
      VGA_VS      <= ~s1_vsync;
      VGA_BLANK_n <= s1_visible;
    end
  end

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
  logic [NUM_LAYERS-1:0] sticky, hits;

  assign hits = (s1_visible && opaque[0]) ? {opaque[NUM_LAYERS-1:1], 1'b0} : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky    <= '0;
      collision <= '0;
    end else if (frame_start) begin
      collision <= sticky;
      sticky    <= hits;
    end else begin
      sticky    <= sticky | hits;
    end
  end
`else
  assign collision = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed + randomized bench for sprite_compositor against a frame-level reference model.
module tb_sprite_compositor;

  localparam int          F   = 800 * 525;
  localparam logic [23:0] TR  = 24'h202020;
  localparam logic [23:0] BGR = 24'h5C94FC;
`ifdef SPRITE_COMPOSITOR_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         write = 1'b0;
  logic [31:0]  writedata = '0;
  logic [191:0] layer_rgb = {8{TR}};
  logic [9:0]   hcount, vcount;
  logic         frame_start;
  logic [7:0]   VGA_R, VGA_G, VGA_B;
  logic         VGA_HS, VGA_VS, VGA_BLANK_n;
  logic [7:0]   collision;

  always #5 clk = ~clk;

  sprite_compositor dut (
    .clk         (clk),
    .reset       (reset),
    .write       (write),
    .writedata   (writedata),
    .layer_rgb   (layer_rgb),
    .hcount      (hcount),
    .vcount      (vcount),
    .frame_start (frame_start),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_n (VGA_BLANK_n),
    .collision   (collision)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;

  logic [7:0]  sh_mask = 8'hFF, ac_mask = 8'hFF;
  logic [23:0] sh_bg = BGR, ac_bg = BGR;
  logic [7:0]  m_sticky = '0, m_coll = '0;
  logic [26:0] pipe1 = {24'h0, 3'b110};
  logic [26:0] pipe2 = {24'h0, 3'b110};
  int hc_err = 0, vga_err = 0, coll_err = 0, fs_cnt = 0;
  int hs_low = 0, vs_low = 0, blank_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] rgb_out();
    return {VGA_R, VGA_G, VGA_B};
  endfunction

  function automatic logic [23:0] compose(input logic [191:0] l, input logic [7:0] m,
                                          input logic [23:0] bg);
    for (int k = 0; k < 8; k++)
      if (m[k] && l[24*k +: 24] != TR) return l[24*k +: 24];
    return bg;
  endfunction

  task automatic observe();
    logic [7:0] exp_coll;
    exp_coll = COLL_EN ? m_coll : 8'h00;
    if (hcount !== 10'(n % 800) || vcount !== 10'((n / 800) % 525)) hc_err++;
    if (frame_start !== ((n % F) == 0)) hc_err++;
    if ({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n} !== pipe2) vga_err++;
    if (collision !== exp_coll) coll_err++;
    if (n >= 2 && n < F + 2) begin
      hs_low    += int'(!VGA_HS);
      vs_low    += int'(!VGA_VS);
      blank_cnt += int'(VGA_BLANK_n);
    end
    if (n < F && frame_start) fs_cnt++;
  endtask

  // Advance one pixel; the model consumes this cycle's inputs, then outputs are observed.
  task automatic step();
    int x, y;
    logic vis;
    logic [7:0] op;
    logic [23:0] rgb;
    x = n % 800;
    y = (n / 800) % 525;
    @(posedge clk);
    if (x == 0 && y == 0) begin
      ac_mask  = sh_mask;
      ac_bg    = sh_bg;
      m_coll   = m_sticky;
      m_sticky = '0;
    end
    if (write && writedata[31:26] == 6'd0) begin
      case (writedata[20:17])
        4'h1: sh_mask = writedata[7:0];
        4'h2: begin
          if (writedata[16:14] == 3'd0) sh_bg[23:16] = writedata[7:0];
          if (writedata[16:14] == 3'd1) sh_bg[15:8]  = writedata[7:0];
          if (writedata[16:14] == 3'd2) sh_bg[7:0]   = writedata[7:0];
        end
        4'hF: begin sh_mask = 8'hFF; sh_bg = BGR; end
        default: ;
      endcase
    end
    vis = (x < 640) && (y < 480);
    for (int k = 0; k < 8; k++) op[k] = ac_mask[k] && (layer_rgb[24*k +: 24] != TR);
    rgb = vis ? compose(layer_rgb, ac_mask, ac_bg) : 24'h0;
    if (vis && op[0]) m_sticky = m_sticky | (op & 8'hFE);
    pipe2 = pipe1;
    pipe1 = {rgb, !(x >= 656 && x < 752), !(y >= 490 && y < 492), vis};
    n++;
    @(negedge clk);
    write = 1'b0;
    observe();
  endtask

  task automatic goto(input int target);
    while (n < target) step();
  endtask

  task automatic send(input logic [5:0] comp, input logic [3:0] act, input logic [2:0] typ,
                      input logic [12:0] data);
    write = 1'b1;
    writedata = {comp, 5'd0, act, typ, 1'b0, data};
    step();
  endtask

  task automatic set_layer(input int k, input logic [23:0] v);
    layer_rgb[24*k +: 24] = v;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hcount", 32'(hcount), 32'd0);
    check("rst_rgb", 32'(rgb_out()), 32'h0);
    check("rst_sync", {29'd0, VGA_HS, VGA_VS, VGA_BLANK_n}, 32'b110);
    check("rst_collision", 32'(collision), 32'h0);

    reset = 1'b0;
    observe();
    check("release_frame_start", 32'(frame_start), 32'd1);

    // The red write lands in the frame_start cycle, so it must wait a full frame.
    send(6'd0, 4'h2, 3'd0, 13'h12);
    send(6'd0, 4'h2, 3'd1, 13'h34);
    send(6'd0, 4'h2, 3'd2, 13'h56);
    goto(10 * 800 + 7);
    check("bg_before_commit", 32'(rgb_out()), 32'(BGR));

    goto(50 * 800 + 100);
    check("counters_100_50", {6'd0, vcount, 6'd0, hcount}, {6'd0, 10'd50, 6'd0, 10'd100});
    set_layer(3, 24'hFF0000);
    step();
    set_layer(3, TR);
    step();
    check("layer3_pixel", 32'(rgb_out()), 32'hFF0000);
    check("layer3_blank_n", 32'(VGA_BLANK_n), 32'd1);

    goto(100 * 800 + 10);
    set_layer(1, 24'h00FF00);
    set_layer(2, 24'h0000FF);
    step();
    step();
    check("prio_l1_over_l2", 32'(rgb_out()), 32'h00FF00);
    goto(100 * 800 + 20);
    send(6'd0, 4'h1, 3'd0, 13'h0FD);
    goto(300 * 800 + 50);
    check("mask_held_midframe", 32'(rgb_out()), 32'h00FF00);
    goto(310 * 800);
    send(6'h05, 4'h1, 3'd0, 13'h000);

    goto(320 * 800 + 200);
    layer_rgb = {8{TR}};
    set_layer(0, 24'hABCDEF);
    set_layer(4, 24'h111111);
    step();
    layer_rgb = {8{TR}};
    set_layer(1, 24'h00FF00);
    set_layer(2, 24'h0000FF);
    step();
    check("layer0_top", 32'(rgb_out()), 32'hABCDEF);

    goto(F);
    check("frame_start_wrap", 32'(frame_start), 32'd1);
    check("frame0_fs_count", 32'(fs_cnt), 32'd1);
    send(6'd0, 4'hF, 3'd0, 13'h0);
    check("collision_commit", 32'(collision), COLL_EN ? 32'h10 : 32'h0);
    check("frame0_hs_low", 32'(hs_low), 32'(96 * 525));
    check("frame0_vs_low", 32'(vs_low), 32'(2 * 800));
    check("frame0_blank_n", 32'(blank_cnt), 32'(640 * 480));

    goto(F + 30 * 800 + 12);
    check("mask_fd_applied", 32'(rgb_out()), 32'h0000FF);
    goto(F + 40 * 800);
    layer_rgb = {8{TR}};
    goto(F + 40 * 800 + 12);
    check("bg_committed", 32'(rgb_out()), 32'h123456);

    goto(F + 50 * 800);
    for (int i = 0; i < 2400; i++) begin
      for (int k = 1; k < 8; k++)
        set_layer(k, ($urandom_range(0, 2) == 0) ? TR : 24'($urandom));
      step();
    end
    layer_rgb = {8{TR}};

    goto(2 * F);
    check("frame_start_wrap2", 32'(frame_start), 32'd1);
    step();
    check("collision_cleared", 32'(collision), 32'h0);
    goto(2 * F + 2 * 800 + 10);
    check("restore_bg", 32'(rgb_out()), 32'(BGR));
    set_layer(1, 24'h00FF00);
    set_layer(2, 24'h0000FF);
    step();
    step();
    check("restore_mask", 32'(rgb_out()), 32'h00FF00);

    check("counter_trace", 32'(hc_err), 32'd0);
    check("vga_trace", 32'(vga_err), 32'd0);
    check("collision_trace", 32'(coll_err), 32'd0);

    goto(2 * F + 5 * 800 + 300);
    reset = 1'b1;
    #1;
    check("arst_counters", {6'd0, vcount, 6'd0, hcount}, 32'd0);
    check("arst_rgb", 32'(rgb_out()), 32'h0);
    check("arst_sync", {29'd0, VGA_HS, VGA_VS, VGA_BLANK_n}, 32'b110);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_release_fs", 32'(frame_start), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
